render_slave_regs: RTL
======================

# render_slave_regs

Avalon-MM slave front end of the renderer: it accepts register writes from the HPS or a bench master and latches X, Y and texture code. Each PLOT write is turned into a queued draw command for the draw engine. The block sits between the bus master (`slave_*` signals) and the draw engine command port, and reports queue and engine status back to the master.

## Interface
- `DEPTH`, 8: command FIFO depth; a power of two, at least 2.
- `ID_VALUE`, 32'h52454E44: constant returned at address 7.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset. One clock; the reset is asynchronous and active-high.
- `slave_address` in 4: register word address.
- `slave_read` in 1: read strobe.
- `slave_write` in 1: write strobe.
- `slave_writedata` in 32: write data.
- `slave_readdata` out 32: read data.
- `slave_waitrequest` out 1: high means the current transfer is stalled.
- `cmd_valid` out 1: a draw command is presented.
- `cmd_ready` in 1: the engine accepts the command.
- `cmd_x` out 9: command X coordinate, 0..319.
- `cmd_y` out 8: command Y coordinate, 0..239.
- `cmd_tex` out 7: command texture code.
- `engine_busy` in 1: the engine is rendering; status only.

## Operation
- Register map (word address, effect):
  - 0 STATUS, read-only: bit0 `engine_busy`, bit1 FIFO empty, bit2 FIFO full, bit3 sticky range error.
  - 1 X: read/write, 9 bits.
  - 2 Y: read/write, 8 bits.
  - 3 COUNT: read-only, FIFO occupancy in `$clog2(DEPTH)+1` bits.
  - 4 TEX: read/write, 7 bits.
  - 5 CLEAR: write-only. Any data flushes the FIFO. Data bit0 = 1 also clears the range error.
  - 6 PLOT: write-only. Pushes {TEX, X, Y}; the data value is ignored.
  - 7 ID: returns `ID_VALUE`.
  - All other addresses read 0; writes to them are ignored.
- Unused read bits return 0.
- Range checks:
  - A write to X with `writedata > 319` leaves X unchanged and sets the range error bit.
  - A write to Y with `writedata > 239` behaves the same way.
- PLOT uses the X, Y and TEX values that were registered before the PLOT cycle.
- Write accepted means `slave_write` is high and `slave_waitrequest` is low in the same cycle.
- Read handshake, two states: R_IDLE and R_ACK.
  - R_IDLE with `slave_read` high: capture readdata, drive `waitrequest` high, go to R_ACK.
  - R_ACK: `waitrequest` low, `readdata` valid, return to R_IDLE.
- `slave_read` and `slave_write` high together: the write is serviced and the read is ignored.

## Timing
- Reset values:
  - `slave_readdata` = 0, `cmd_valid` = 0, `cmd_x`/`cmd_y`/`cmd_tex` = 0.
  - X = 0, Y = 0, TEX = 0; FIFO empty; error = 0; read FSM in R_IDLE.
  - `slave_waitrequest` = 1 while `rst` is high.
- Reset asserted mid-transfer or mid-command: all state returns to reset values immediately; queued commands are lost.
- Register writes: 0 wait cycles; the new value is readable on the next read.
- `waitrequest` is combinational and is high in any of these cases:
  - `rst` is high;
  - PLOT write while the FIFO is full;
  - `slave_read` is high in R_IDLE.
- FIFO full: a PLOT write stalls even if a pop happens in the same cycle. It is accepted in the first cycle with registered full = 0.
- FIFO output:
  - `cmd_valid` = FIFO not empty; `cmd_*` show the head entry.
  - Pop happens on `cmd_valid & cmd_ready`.
  - An empty-to-nonempty push raises `cmd_valid` on the next cycle, so push-to-valid latency is 1.
- Simultaneous push and pop on a non-empty FIFO: COUNT is unchanged.
- CLEAR in the same cycle as a pop: the popped command counts as delivered. COUNT = 0 and `cmd_valid` = 0 from the next cycle.
- CLEAR in the same cycle as a PLOT to a non-full FIFO: CLEAR wins and the push is discarded.
- Pointers wrap modulo DEPTH. COUNT saturates at DEPTH by construction.

## Structure
- Package `render_pkg`:
  - register address localparams (`REG_STATUS` .. `REG_ID`);
  - `X_W=9`, `Y_W=8`, `TEX_W=7`, `X_MAX=319`, `Y_MAX=239`;
  - packed struct `render_cmd_t` {tex, x, y}.
- Sub-module `render_cmd_fifo`: synchronous FIFO of `render_cmd_t`, parameter DEPTH. Ports: push, pop, clear, full, empty, count, head.
- Register file, range check and read FSM live in the top module.

## Test plan
- Reset, then read ID -> `waitrequest` is high for 1 cycle, then readdata = 32'h52454E44. STATUS = 32'h2.
- Write TEX = 'b000_0101, X = 159, Y = 119, then PLOT with `cmd_ready` = 0 -> `cmd_valid` = 1, `cmd_x` = 159, `cmd_y` = 119, `cmd_tex` = 5, COUNT = 1.
- Hold `cmd_ready` = 0 and issue 9 PLOTs with DEPTH = 8:
  - the 9th write sees `waitrequest` = 1;
  - raise `cmd_ready` for 1 cycle -> the 9th write is accepted the next cycle and COUNT = 8.
- Write X = 320 -> X still reads its prior value and STATUS bit3 = 1. Write CLEAR with data 1 -> bit3 = 0 and COUNT = 0.
- With `cmd_ready` = 1 continuously, issue back-to-back PLOTs with x = 0, 19, 159 -> the engine receives them in order, one per cycle, and COUNT stays ≤ 1.
- Assert `rst` with 3 commands queued and a read in R_ACK -> next cycle `cmd_valid` = 0, COUNT = 0, X = Y = TEX = 0, `slave_readdata` = 0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared definitions for the renderer slave front end: register map,
// coordinate widths and limits, and the queued draw command layout.
package render_pkg;

    localparam logic [3:0] REG_STATUS = 4'd0;
    localparam logic [3:0] REG_X      = 4'd1;
    localparam logic [3:0] REG_Y      = 4'd2;
    localparam logic [3:0] REG_COUNT  = 4'd3;
    localparam logic [3:0] REG_TEX    = 4'd4;
    localparam logic [3:0] REG_CLEAR  = 4'd5;
    localparam logic [3:0] REG_PLOT   = 4'd6;
    localparam logic [3:0] REG_ID     = 4'd7;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int TEX_W = 7;

    localparam logic [31:0] X_MAX = 32'd319;
    localparam logic [31:0] Y_MAX = 32'd239;

    typedef struct packed {
        logic [TEX_W-1:0] tex;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
    } render_cmd_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } read_state_t;

    // Whole bus word is compared so high garbage bits also count as out of range.
    function automatic logic in_range(input logic [31:0] value, input logic [31:0] max);
        return value <= max;
    endfunction

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO between the register front end and the draw engine.
// Clear has priority over push; head reads as zero whenever the FIFO is empty.
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  render_cmd_t   push_cmd,
    input  logic          pop,
    input  logic          clear,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output render_cmd_t   head
);

    render_cmd_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            // A pop in the same cycle is still delivered; everything else is dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

endmodule

// File: rtl/render_slave_regs.sv
// Avalon-MM register front end of the renderer: holds X/Y/TEX, range-checks
// coordinate writes, queues PLOT commands and answers reads with one wait state.
module render_slave_regs
    import render_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] ID_VALUE = 32'h52454E44,
    localparam int CW = $clog2(DEPTH) + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       slave_address,
    input  logic             slave_read,
    input  logic             slave_write,
    input  logic [31:0]      slave_writedata,
    output logic [31:0]      slave_readdata,
    output logic             slave_waitrequest,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [X_W-1:0]   cmd_x,
    output logic [Y_W-1:0]   cmd_y,
    output logic [TEX_W-1:0] cmd_tex,
    input  logic             engine_busy
);

    read_state_t      read_state;
    read_state_t      read_state_nxt;
    logic             capture;

    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [TEX_W-1:0] tex_reg;
    logic             range_err;

    logic             read_req;
    logic             plot_stall;
    logic             wr_accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    render_cmd_t      fifo_head;
    render_cmd_t      plot_cmd;
    logic [31:0]      rd_mux;

    // A write always wins the bus, so a read only counts when write is low.
    assign read_req          = slave_read && !slave_write;
    assign plot_stall        = slave_write && (slave_address == REG_PLOT) && fifo_full;
    assign slave_waitrequest = rst || plot_stall || (read_req && (read_state == R_IDLE));
    assign wr_accept         = slave_write && !slave_waitrequest;

    assign fifo_push  = wr_accept && (slave_address == REG_PLOT);
    assign fifo_clear = wr_accept && (slave_address == REG_CLEAR);
    assign fifo_pop   = cmd_valid && cmd_ready;
    assign plot_cmd   = '{tex: tex_reg, x: x_reg, y: y_reg};

    assign cmd_valid = !fifo_empty;
    assign cmd_x     = fifo_head.x;
    assign cmd_y     = fifo_head.y;
    assign cmd_tex   = fifo_head.tex;

    render_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_cmd (plot_cmd),
        .pop      (fifo_pop),
        .clear    (fifo_clear),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    always_comb begin
        read_state_nxt = read_state;
        capture        = 1'b0;
        case (read_state)
            R_IDLE: begin
                if (read_req) begin
                    capture        = 1'b1;
                    read_state_nxt = R_ACK;
                end
            end
            R_ACK: begin
                read_state_nxt = R_IDLE;
            end
            default: begin
                read_state_nxt = R_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            REG_STATUS: rd_mux = {28'd0, range_err, fifo_full, fifo_empty, engine_busy};
            REG_X:      rd_mux = 32'(x_reg);
            REG_Y:      rd_mux = 32'(y_reg);
            REG_COUNT:  rd_mux = 32'(fifo_count);
            REG_TEX:    rd_mux = 32'(tex_reg);
            REG_ID:     rd_mux = ID_VALUE;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_state     <= R_IDLE;
            slave_readdata <= '0;
        end else begin
            read_state <= read_state_nxt;
            if (capture) begin
                slave_readdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            tex_reg   <= '0;
            range_err <= 1'b0;
        end else if (wr_accept) begin
            case (slave_address)
                REG_X: begin
                    if (in_range(slave_writedata, X_MAX)) x_reg <= slave_writedata[X_W-1:0];
                    else                                  range_err <= 1'b1;
                end
                REG_Y: begin
                    if (in_range(slave_writedata, Y_MAX)) y_reg <= slave_writedata[Y_W-1:0];
                    else                                  range_err <= 1'b1;
                end
                REG_TEX: tex_reg <= slave_writedata[TEX_W-1:0];
                REG_CLEAR: begin
                    if (slave_writedata[0]) range_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
